// File: rtl/candy_control.sv
`default_nettype none
// ============================================================================
// Module      : candy_control
// Description : Vending machine control core: coin credit, vend, change.
// Revision    : 1.0 - initial release
// ============================================================================
module candy_control #(
    parameter int PRICE   = 3,
    parameter int MAX_SUM = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] in,
    output logic [3:0] sum,
    output logic [2:0] candy_sum,
    output logic [4:0] can_buy
);

    localparam logic [2:0] c_cmd_coin1  = 3'b001;
    localparam logic [2:0] c_cmd_coin5  = 3'b010;
    localparam logic [2:0] c_cmd_coin10 = 3'b011;
    localparam logic [2:0] c_cmd_vend   = 3'b101;
    localparam logic [2:0] c_cmd_change = 3'b110;
    localparam logic [2:0] c_cmd_clear  = 3'b111;
    localparam logic [2:0] c_candy_max  = 3'b111;

    logic [3:0] sum_q, sum_d;
    logic [2:0] candy_sum_q, candy_sum_d;
    logic [3:0] w_coin;
    logic [4:0] w_total;

    always_comb begin
        w_coin = 4'd0;
        case (in)
            c_cmd_coin1:  w_coin = 4'd1;
            c_cmd_coin5:  w_coin = 4'd5;
            c_cmd_coin10: w_coin = 4'd10;
            default:      w_coin = 4'd0;
        endcase
    end

    // One extra bit so the ceiling test cannot itself wrap.
    assign w_total = {1'b0, sum_q} + {1'b0, w_coin};

    always_comb begin
        sum_d       = sum_q;
        candy_sum_d = candy_sum_q;
        case (in)
            c_cmd_coin1, c_cmd_coin5, c_cmd_coin10: begin
                if (w_total <= 5'(MAX_SUM)) begin
                    sum_d = w_total[3:0];
                end
            end
            c_cmd_vend: begin
                if (sum_q >= 4'(PRICE)) begin
                    sum_d = sum_q - 4'(PRICE);
                    if (candy_sum_q != c_candy_max) begin
                        candy_sum_d = candy_sum_q + 3'd1;
                    end
                end
            end
            c_cmd_change, c_cmd_clear: begin
                sum_d       = 4'd0;
                candy_sum_d = 3'd0;
            end
            default: begin
                sum_d       = sum_q;
                candy_sum_d = candy_sum_q;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q       <= 4'd0;
            candy_sum_q <= 3'd0;
        end else begin
            sum_q       <= sum_d;
            candy_sum_q <= candy_sum_d;
        end
    end

    generate
        for (genvar k = 0; k < 5; k++) begin : g_can_buy
            localparam int THR = (k + 1) * PRICE;
            assign can_buy[k] = (32'(sum_q) >= THR);
        end
    endgenerate

    assign sum       = sum_q;
    assign candy_sum = candy_sum_q;

endmodule
`default_nettype wire

// File: tb/tb_candy_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_candy_control
// Description : Directed and random checks of candy_control against a model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_candy_control;

    logic       clk;
    logic       rst;
    logic [2:0] in;
    logic [3:0] sum;
    logic [2:0] candy_sum;
    logic [4:0] can_buy;

    int checks = 0;
    int errors = 0;
    int m_sum   = 0;
    int m_candy = 0;

    candy_control #(.PRICE(3), .MAX_SUM(15)) dut (
        .clk       (clk),
        .rst       (rst),
        .in        (in),
        .sum       (sum),
        .candy_sum (candy_sum),
        .can_buy   (can_buy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: credit in whole units, rules applied arithmetically.
    task automatic model_apply(input logic [2:0] c);
        int v;
        v = (c == 3'd1) ? 1 : (c == 3'd2) ? 5 : (c == 3'd3) ? 10 : 0;
        if (v != 0) begin
            if (m_sum + v <= 15) m_sum = m_sum + v;
        end else if (c == 3'd5) begin
            if (m_sum >= 3) begin
                m_sum   = m_sum - 3;
                m_candy = (m_candy < 7) ? m_candy + 1 : 7;
            end
        end else if (c == 3'd6 || c == 3'd7) begin
            m_sum   = 0;
            m_candy = 0;
        end
    endtask

    task automatic check(input string tag);
        logic [4:0] exp_cb;
        for (int k = 0; k < 5; k++) exp_cb[k] = (m_sum >= (k + 1) * 3);
        checks++;
        assert (sum === 4'(m_sum)) else begin
            errors++;
            $error("FAIL %s sum observed=%0d expected=%0d", tag, sum, m_sum);
        end
        checks++;
        assert (candy_sum === 3'(m_candy)) else begin
            errors++;
            $error("FAIL %s candy_sum observed=%0d expected=%0d", tag, candy_sum, m_candy);
        end
        checks++;
        assert (can_buy === exp_cb) else begin
            errors++;
            $error("FAIL %s can_buy observed=%b expected=%b", tag, can_buy, exp_cb);
        end
    endtask

    task automatic do_cmd(input logic [2:0] c, input string tag);
        in = c;
        @(posedge clk);
        #1;
        model_apply(c);
        check(tag);
    endtask

    initial begin
        rst = 1'b1;
        in  = 3'b000;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset");
        rst = 1'b0;
        do_cmd(3'b000, "idle_after_reset");
        do_cmd(3'b111, "clear_at_zero");

        do_cmd(3'b010, "coin5_a");
        do_cmd(3'b000, "idle_a");
        do_cmd(3'b010, "coin5_b");
        do_cmd(3'b000, "idle_b");
        do_cmd(3'b101, "vend1");
        do_cmd(3'b101, "vend2");
        do_cmd(3'b101, "vend3");
        do_cmd(3'b101, "vend_short");
        do_cmd(3'b110, "change");

        do_cmd(3'b011, "coin10");
        do_cmd(3'b010, "coin5_to_15");
        do_cmd(3'b001, "coin1_reject");
        do_cmd(3'b100, "reserved_idle");
        do_cmd(3'b111, "clear");

        for (int r = 0; r < 3; r++) begin
            do_cmd(3'b011, "sat_coin");
            for (int v = 0; v < 3; v++) do_cmd(3'b101, "sat_vend");
        end
        do_cmd(3'b011, "sat_coin_last");
        do_cmd(3'b101, "sat_vend_at7");
        do_cmd(3'b101, "sat_vend_at7_again");

        // Asynchronous reset mid-cycle must clear outputs without a clock edge.
        #2;
        rst = 1'b1;
        #1;
        m_sum   = 0;
        m_candy = 0;
        check("async_reset");
        #1;
        rst = 1'b0;
        do_cmd(3'b010, "post_reset_coin");

        for (int i = 0; i < 400; i++) begin
            logic [2:0] c;
            c = 3'($urandom_range(0, 7));
            // Bias away from clear/change so credit builds up.
            if ((c == 3'd6 || c == 3'd7) && ($urandom_range(0, 3) != 0)) c = 3'd5;
            do_cmd(c, "random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
